// File: rtl/display_pkg.sv
// Shared constants and types for the seven-segment scan controller.
package display_pkg;

    localparam int MAX_DIGITS = 8;

    // Active-low segment patterns {g,f,e,d,c,b,a}; entry 15 first, entry 0 last.
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    localparam logic [6:0]            SEG_OFF   = 7'h7F;
    localparam logic [MAX_DIGITS-1:0] ANODE_OFF = '1;

    typedef enum logic {
        IDLE,
        SCAN
    } state_t;

endpackage

// File: rtl/hex_to_seg.sv
// Combinational hex nibble to active-low seven-segment decoder.
module hex_to_seg
    import display_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [6:0] o_seg
);

    assign o_seg = SEG_TABLE[i_nibble];

endmodule

// File: rtl/display_scan.sv
// Seven-segment scan controller for a common-anode display.
// Synchronises the slow refresh clock, steps one digit per rising edge with a
// one-cycle blank slot between digits, and latches a whole frame of inputs at
// each frame boundary so a value never tears mid-frame.
// Optional build macro: LEADING_ZERO_BLANK_EN (auto-blank leading zero digits).
//
// state | meaning
// IDLE  | after reset, display dark, waiting for the first refresh edge
// SCAN  | cycling through digits, one per refresh edge
module display_scan
    import display_pkg::*;
#(
    parameter int DIGITS      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_refresh_clk,
    input  logic [4*DIGITS-1:0]   i_data,
    input  logic [DIGITS-1:0]     i_dp_in,
    input  logic [DIGITS-1:0]     i_blank_mask,
    output logic [DIGITS-1:0]     o_anode,
    output logic [6:0]            o_seg,
    output logic                  o_dp,
    output logic                  o_frame_done
);

    localparam int                IDX_W        = $clog2(DIGITS);
    localparam logic [DIGITS-1:0] ANODE_DARK   = ANODE_OFF[DIGITS-1:0];
    localparam logic [DIGITS-1:0] ONE_HOT_BASE = {{(DIGITS-1){1'b0}}, 1'b1};

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_hist;
    logic                   r_step;

    state_t                 r_state;
    logic [IDX_W-1:0]       r_idx;
    logic [4*DIGITS-1:0]    r_snap_data;
    logic [DIGITS-1:0]      r_snap_dp;
    logic [DIGITS-1:0]      r_snap_blank;
    logic                   r_blank_slot;
    logic [DIGITS-1:0]      r_anode;
    logic [6:0]             r_seg;
    logic                   r_dp;
    logic                   r_frame_done;

    logic [DIGITS-1:0]      w_blank_in;
    logic                   w_reload;
    logic [IDX_W-1:0]       w_next_idx;
    logic [4*DIGITS-1:0]    w_next_data;
    logic [DIGITS-1:0]      w_next_dp;
    logic [DIGITS-1:0]      w_next_blank;
    logic [3:0]             w_next_nibble;
    logic                   w_next_dp_bit;
    logic                   w_next_blank_bit;
    logic [6:0]             w_dec_seg;
    logic [6:0]             w_next_seg;
    logic                   w_next_dp_out;
    logic [DIGITS-1:0]      w_anode_on;

    // Synchronise refresh_clk and register a one-cycle pulse per rising edge.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync <= '0;
            r_hist <= 1'b0;
            r_step <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_refresh_clk};
            r_hist <= r_sync[SYNC_STAGES-1];
            r_step <= r_sync[SYNC_STAGES-1] & ~r_hist;
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    // Blank zero nibbles from the top digit down until a nonzero nibble or a lit decimal point; digit 0 always shows.
    always_comb begin : lzb_calc
        logic v_suppress;
        w_blank_in = i_blank_mask;
        v_suppress = 1'b1;
        for (int i = DIGITS-1; i > 0; i--) begin
            if (v_suppress && (i_data[4*i +: 4] == 4'h0) && !i_dp_in[i]) begin
                w_blank_in[i] = 1'b1;
            end else begin
                v_suppress = 1'b0;
            end
        end
    end
`else
    assign w_blank_in = i_blank_mask;
`endif

    // Work out which digit and snapshot the next step will show, so seg/dp change together with the blank slot.
    always_comb begin
        w_reload         = (r_state == IDLE) || (r_idx == IDX_W'(DIGITS-1));
        w_next_idx       = w_reload ? '0 : r_idx + 1'b1;
        w_next_data      = w_reload ? i_data     : r_snap_data;
        w_next_dp        = w_reload ? i_dp_in    : r_snap_dp;
        w_next_blank     = w_reload ? w_blank_in : r_snap_blank;
        w_next_nibble    = 4'h0;
        w_next_dp_bit    = 1'b0;
        w_next_blank_bit = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (w_next_idx == IDX_W'(i)) begin
                w_next_nibble    = w_next_data[4*i +: 4];
                w_next_dp_bit    = w_next_dp[i];
                w_next_blank_bit = w_next_blank[i];
            end
        end
    end

    hex_to_seg u_hex_to_seg (
        .i_nibble (w_next_nibble),
        .o_seg    (w_dec_seg)
    );

    assign w_next_seg    = w_next_blank_bit ? SEG_OFF : w_dec_seg;
    assign w_next_dp_out = w_next_blank_bit | ~w_next_dp_bit;
    assign w_anode_on    = ~(ONE_HOT_BASE << r_idx);

    // Scan FSM: a step opens a blank slot and selects the next digit; the slot closes by lighting that digit.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= IDLE;
            r_idx        <= '0;
            r_snap_data  <= '0;
            r_snap_dp    <= '0;
            r_snap_blank <= '0;
            r_blank_slot <= 1'b0;
            r_anode      <= ANODE_DARK;
            r_seg        <= SEG_OFF;
            r_dp         <= 1'b1;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            if (r_step) begin
                r_state      <= SCAN;
                r_idx        <= w_next_idx;
                r_blank_slot <= 1'b1;
                r_anode      <= ANODE_DARK;
                r_seg        <= w_next_seg;
                r_dp         <= w_next_dp_out;
                if (w_reload) begin
                    r_snap_data  <= i_data;
                    r_snap_dp    <= i_dp_in;
                    r_snap_blank <= w_blank_in;
                    r_frame_done <= 1'b1;
                end
            end else if ((r_state == SCAN) && r_blank_slot) begin
                r_blank_slot <= 1'b0;
                r_anode      <= w_anode_on;
            end
        end
    end

    assign o_anode      = r_anode;
    assign o_seg        = r_seg;
    assign o_dp         = r_dp;
    assign o_frame_done = r_frame_done;

endmodule

// File: doc/display_scan.md
# display_scan

Seven-segment scan controller that consumes the slow refresh clock produced by the system clock divider (500 Hz level signal) and time-multiplexes a DIGITS-wide hex value onto a common-anode display. It sits between the processor's output register and the board pins. It synchronises the divided clock back into the fast domain and steps one digit per refresh edge, with an anti-ghosting blank slot and tear-free frame latching.

## Interface
- DIGITS, 8: number of display digits; legal range 2–8.
- SYNC_STAGES, 2: synchroniser depth for refresh_clk; minimum 2.

- clk  in  1  system clock, also the clock driving the divider.
- rst  in  1  synchronous, active-high reset.
- refresh_clk  in  1  divided clock level (500 Hz); asynchronous to clk for timing purposes.
- data  in  4*DIGITS  hex nibbles; digit i = data[4i+3:4i]; digit 0 is rightmost.
- dp_in  in  DIGITS  decimal-point request per digit, active-high.
- blank_mask  in  DIGITS  1 = force digit dark.
- anode  out  DIGITS  digit enables, active-low, one-hot-low when lit.
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low.
- dp  out  1  decimal point, active-low.
- frame_done  out  1  one-cycle pulse at every frame boundary.

## Operation
- refresh_clk passes through a SYNC_STAGES flop chain plus one history flop. step = synced & ~history, which gives one clk-cycle pulse per rising edge. Falling edges are ignored.
- States: IDLE (after reset, display dark) and SCAN.
- IDLE: on step, load snapshot ← data, dp_in, blank_mask; set idx = 0; go to BLANK slot; pulse frame_done.
- SCAN, on step: anode ← all 1s for exactly one cycle (blank slot); idx advances; seg/dp update to the new digit. The next cycle drives anode[idx] = 0.
- Wrap: when idx = DIGITS-1 and step occurs, idx ← 0, the snapshot reloads from inputs in the same cycle, and frame_done pulses. Input changes mid-frame are not visible until the next frame.
- Digit output: seg = hex_to_seg(snapshot nibble[idx]); dp = ~snapshot_dp[idx]. A digit with snapshot_blank[idx] = 1 drives seg = 7'h7F and dp = 1, while its anode still cycles (constant brightness).
- Encoding, active-low: 0→40, 1→79, 2→24, 3→30, 4→19, 5→12, 6→02, 7→78, 8→00, 9→10, A→08, b→03, C→46, d→21, E→06, F→0E.

## Timing
- Reset values: anode = all 1s, seg = 7'h7F, dp = 1, frame_done = 0, idx = 0, snapshot = 0, synchroniser = 0, state IDLE.
- Reset is honoured in any cycle, including mid-frame or in the blank slot. The display goes dark on the next edge.
- Latency with SYNC_STAGES = 2: refresh_clk rise captured at edge k. step is high during cycle k+2. Blank slot and idx update at edge k+3. New anode low at edge k+4.
- A step arriving during the blank slot cannot occur at 500 Hz vs ≥ 1 MHz clk. If it does occur, it is honoured: idx advances again and the blank slot restarts.
- Frame rate = refresh rate / DIGITS (62.5 Hz at 8 digits).

## Configuration
- LEADING_ZERO_BLANK_EN defined: at snapshot load, zero nibbles from digit DIGITS-1 downward are additionally blanked, up to the first nonzero nibble. Digit 0 is never auto-blanked. dp_in = 1 on a digit stops suppression at that digit.
- Not defined: only blank_mask blanks digits.

## Structure
- Package display_pkg: 16-entry segment constant table, SEG_OFF = 7'h7F, ANODE_OFF, and the state enum {IDLE, SCAN}.
- Sub-module hex_to_seg: combinational 4-bit → 7-bit active-low decoder using the package table.
- Top block holds the synchroniser, edge detect, idx counter, snapshot registers, blank-slot flag and output registers. All outputs are registered.

## Test plan
- Reset check: hold rst for 3 cycles with refresh_clk toggling → anode = FF, seg = 7F, dp = 1, and no frame_done during reset or until the first refresh rise.
- Scan of a known value: data = 32'h0123ABCD, DIGITS = 8, 16 refresh edges → digit 0 shows seg 21, digit 7 shows seg 40. The anode sequence is FE, FD, … 7F, FE. Every digit change is preceded by exactly one FF cycle. frame_done pulses twice.
- Tear-free latching: change data to 32'hFFFFFFFF at idx = 3 → digits 3–7 of the current frame still show the old value; the next frame shows all 0E.
- Edge filtering: refresh_clk high for 40 cycles, then low → exactly one step. Pulse width and falling edge cause no extra advance.
- Masking and decimal points: blank_mask = 8'h80, dp_in = 8'h01 → digit 7 shows seg 7F and dp 1; digit 0 shows dp 0.
- Leading-zero blanking: with LEADING_ZERO_BLANK_EN, data = 32'h00000050 → digits 7–2 show 7F, digit 1 shows 12, digit 0 shows 40. With data = 0, only digit 0 is lit (40).
